// File: rtl/veggie_pkg.sv
// Shared constants and types for the frame buffer write side.
//   H_RES/V_RES : visible resolution in pixels/lines
//   ADDR_W/PIX_W: frame buffer address and palette index widths
//   frame_writer_state_t : rectangle fill FSM states
//   fill_cmd_t  : latched fill command (x, y, w, h, color)
package veggie_pkg;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 8;

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} frame_writer_state_t;

  typedef struct packed {
    logic [9:0]       x;
    logic [8:0]       y;
    logic [9:0]       w;
    logic [8:0]       h;
    logic [PIX_W-1:0] color;
  } fill_cmd_t;

  // y*640 as two shifts; 511*640 still fits in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] row_base(input logic [8:0] y);
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 9) + (yy << 7);
  endfunction
endpackage

// File: rtl/frame_clipper.sv
// Extent computation for a fill command: exclusive right/bottom edges and
// an empty flag. Combinational; the parent registers the result in SETUP.
// Build option: FRAME_WRITER_CLIP_EN clamps the edges to the screen; when
// undefined the edges are passed through unclamped.
//   i_cmd   : latched command
//   o_x_end : x + w (11 bit), clamped to H_RES when clipping
//   o_y_end : y + h (10 bit), clamped to V_RES when clipping
//   o_empty : no pixel to write
module frame_clipper
  import veggie_pkg::*;
(
  input  fill_cmd_t   i_cmd,
  output logic [10:0] o_x_end,
  output logic [9:0]  o_y_end,
  output logic        o_empty
);
  logic [10:0] w_x_sum;
  logic [9:0]  w_y_sum;

  always_comb begin
    w_x_sum = {1'b0, i_cmd.x} + {1'b0, i_cmd.w};
    w_y_sum = {1'b0, i_cmd.y} + {1'b0, i_cmd.h};
`ifdef FRAME_WRITER_CLIP_EN
    o_x_end = (w_x_sum > 11'(H_RES)) ? 11'(H_RES) : w_x_sum;
    o_y_end = (w_y_sum > 10'(V_RES)) ? 10'(V_RES) : w_y_sum;
`else
    o_x_end = w_x_sum;
    o_y_end = w_y_sum;
`endif
    // An origin at/after the clamped edge (off-screen start) is also empty.
    o_empty = (o_x_end <= {1'b0, i_cmd.x}) || (o_y_end <= {1'b0, i_cmd.y});
  end
endmodule

// File: rtl/frame_writer.sv
// Rectangle fill engine on the frame buffer write port: accepts one command
// over valid/ready, then writes one pixel per clock in row-major order.
// Build option: FRAME_WRITER_CLIP_EN (see frame_clipper).
//   Clk, Reset        : clock, async active-high reset
//   cmd_*             : fill command and handshake (cmd_ready high in IDLE)
//   busy, done        : not-IDLE status, one-cycle completion pulse
//   frame_wrAddress/frame_input/frame_we : buffer write port (registered)
module frame_writer
  import veggie_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x,
  input  logic [8:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic [PIX_W-1:0]  cmd_color,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] frame_wrAddress,
  output logic [PIX_W-1:0]  frame_input,
  output logic              frame_we
);
  frame_writer_state_t r_state;
  fill_cmd_t           r_cmd;
  logic [10:0]         r_x_cur, r_x_end;
  logic [9:0]          r_y_cur, r_y_end;
  logic [ADDR_W-1:0]   r_row_base, r_addr;
  logic [PIX_W-1:0]    r_data;
  logic                r_we, r_done;

  logic [10:0]         w_x_end;
  logic [9:0]          w_y_end;
  logic                w_empty, w_row_last, w_last_row;
  logic [ADDR_W-1:0]   w_row_base, w_next_row;

  frame_clipper u_clip (
    .i_cmd   (r_cmd),
    .o_x_end (w_x_end),
    .o_y_end (w_y_end),
    .o_empty (w_empty)
  );

  assign w_row_base = row_base(r_cmd.y);
  assign w_next_row = r_row_base + ADDR_W'(H_RES);
  assign w_row_last = (r_x_cur + 11'd1 == r_x_end);
  assign w_last_row = (r_y_cur + 10'd1 == r_y_end);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_x_cur    <= '0;
      r_x_end    <= '0;
      r_y_cur    <= '0;
      r_y_end    <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_we   <= 1'b0;
          r_done <= 1'b0;
          if (cmd_valid) begin
            r_cmd   <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_x_end    <= w_x_end;
          r_y_end    <= w_y_end;
          r_x_cur    <= {1'b0, r_cmd.x};
          r_y_cur    <= {1'b0, r_cmd.y};
          r_row_base <= w_row_base;
          r_data     <= r_cmd.color;
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            // First pixel goes out on this edge so FILL has no lead-in bubble.
            r_we    <= 1'b1;
            r_addr  <= w_row_base + ADDR_W'(r_cmd.x);
            r_state <= FILL;
          end
        end
        FILL: begin
          if (w_row_last) begin
            if (w_last_row) begin
              r_we    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_x_cur    <= {1'b0, r_cmd.x};
              r_y_cur    <= r_y_cur + 10'd1;
              r_row_base <= w_next_row;
              r_addr     <= w_next_row + ADDR_W'(r_cmd.x);
            end
          end else begin
            r_x_cur <= r_x_cur + 11'd1;
            r_addr  <= r_addr + ADDR_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready       = (r_state == IDLE);
  assign busy            = (r_state != IDLE);
  assign done            = r_done;
  assign frame_we        = r_we;
  assign frame_wrAddress = r_addr;
  assign frame_input     = r_data;
endmodule

// File: tb/tb_frame_writer.sv
module tb_frame_writer;
  import veggie_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_x;
  logic [8:0]        cmd_y;
  logic [9:0]        cmd_w;
  logic [8:0]        cmd_h;
  logic [PIX_W-1:0]  cmd_color;
  logic              busy, done, frame_we;
  logic [ADDR_W-1:0] frame_wrAddress;
  logic [PIX_W-1:0]  frame_input;

  frame_writer dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .busy(busy), .done(done),
    .frame_wrAddress(frame_wrAddress), .frame_input(frame_input),
    .frame_we(frame_we)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_bad = 0;
  int c_n, c_fcyc, c_lcyc, c_done, c_dcnt, c_abad, c_dbad, c_rbad, c_back;
  int wq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns just after the acceptance edge (cycle 0).
  task automatic send(input int x, y, w, h, c, input bit hold);
    int n;
    n = 0;
    cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h); cmd_color = 8'(c);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge Clk); n++; end
    if (!cmd_ready) check("accept_timeout", 0, 1);
    @(posedge Clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Watches cycles 1.. after acceptance, compares every write against a
  // y*640+x model, and ends at the negedge of the cycle after done.
  task automatic collect(input string tag, input int x, y, w, h, c);
    int xe, ye, ew, eh, ne, ea;
    xe = x + w; ye = y + h;
`ifdef FRAME_WRITER_CLIP_EN
    if (xe > 640) xe = 640;
    if (ye > 480) ye = 480;
`endif
    ew = (xe > x) ? xe - x : 0;
    eh = (ye > y) ? ye - y : 0;
    ne = ew * eh;
    c_n = 0; c_fcyc = 0; c_lcyc = 0; c_done = 0; c_dcnt = 0;
    c_abad = 0; c_dbad = 0; c_rbad = 0; c_back = 0;
    wq.delete();
    for (int k = 1; k <= ne + 10; k++) begin
      @(negedge Clk);
      if (frame_we) begin
        if (c_n == 0) c_fcyc = k;
        c_lcyc = k;
        if (c_n >= ne) c_abad++;
        else begin
          ea = ((y + c_n / ew) * 640 + x + c_n % ew) & 32'h7FFFF;
          if (frame_wrAddress !== ea[18:0]) c_abad++;
        end
        if (frame_input !== c[7:0]) c_dbad++;
        wq.push_back(int'(frame_wrAddress));
        c_n++;
      end
      if (done === 1'b1) begin
        c_dcnt++;
        if (c_done == 0) c_done = k;
      end
      if ((c_done == 0 || c_done == k) && (cmd_ready || !busy)) c_rbad++;
      if (c_done != 0 && k == c_done + 1) begin
        c_back = cmd_ready;
        break;
      end
    end
    check({tag, "_nwr"}, c_n, ne);
    check({tag, "_addr_err"}, c_abad, 0);
    check({tag, "_data_err"}, c_dbad, 0);
    check({tag, "_done_cyc"}, c_done, 2 + ne);
    check({tag, "_done_cnt"}, c_dcnt, 1);
    check({tag, "_busy_err"}, c_rbad, 0);
    check({tag, "_ready_back"}, c_back, 1);
    if (ne > 0) begin
      check({tag, "_first_cyc"}, c_fcyc, 2);
      check({tag, "_last_cyc"}, c_lcyc, 1 + ne);
    end
  endtask

  task automatic run(input string tag, input int x, y, w, h, c);
    send(x, y, w, h, c, 1'b0);
    collect(tag, x, y, w, h, c);
  endtask

  initial begin
    Reset = 1'b1; cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    #2;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", frame_we, 0);
    check("rst_addr", frame_wrAddress, 0);
    check("rst_data", frame_input, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // 2x2 at (10,5): rows 5 and 6 -> 3210,3211,3850,3851
    run("t1", 10, 5, 2, 2, 8'h3C);
    check("t1_size", wq.size(), 4);
    if (wq.size() >= 4) begin
      check("t1_a0", wq[0], 3210);
      check("t1_a1", wq[1], 3211);
      check("t1_a2", wq[2], 3850);
      check("t1_a3", wq[3], 3851);
    end

    // zero width / zero height
    run("t2w0", 100, 100, 0, 7, 8'h12);
    run("t2h0", 100, 100, 7, 0, 8'h12);

    // two full rows: contiguous 0..1279, no bubble at the row wrap
    run("t3", 0, 0, 640, 2, 8'h00);
    if (wq.size() == 1280) check("t3_last", wq[1279], 1279);

    // bottom-right corner overrun
    run("t4", 630, 475, 20, 10, 8'hFF);
    if (wq.size() > 20) begin
      check("t4_first", wq[0], 304630);
`ifdef FRAME_WRITER_CLIP_EN
      check("t4_step", wq[10], 305270);
      check("t4_last", wq[wq.size()-1], 307199);
`else
      check("t4_spill", wq[10], 304640);
      check("t4_row2", wq[20], 305270);
      check("t4_last", wq[wq.size()-1], 310409);
`endif
    end

    // last pixel on screen, and an origin beyond the right edge
    run("t5", 639, 479, 1, 1, 8'h5A);
    if (wq.size() == 1) check("t5_addr", wq[0], 307199);
    run("t6", 700, 0, 4, 1, 8'h33);

    // held valid with a second command queued; fields change mid-fill
    send(1, 1, 2, 1, 8'h11, 1'b1);
    cmd_x = 10'd50; cmd_y = 9'd2; cmd_w = 10'd1; cmd_h = 9'd1; cmd_color = 8'h22;
    collect("q1", 1, 1, 2, 1, 8'h11);
    send(50, 2, 1, 1, 8'h22, 1'b0);
    check("q2_accept", busy, 1);
    collect("q2", 50, 2, 1, 1, 8'h22);

    // reset in cycle 4 of a 4x4 fill
    send(3, 3, 4, 4, 8'h77, 1'b0);
    repeat (4) @(negedge Clk);
    check("rm_we_before", frame_we, 1);
    Reset = 1'b1;
    #1;
    check("rm_we", frame_we, 0);
    check("rm_ready", cmd_ready, 1);
    check("rm_busy", busy, 0);
    begin
      int dseen;
      dseen = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge Clk);
        if (done !== 1'b0) dseen++;
      end
      Reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge Clk);
        if (done !== 1'b0) dseen++;
      end
      check("rm_no_done", dseen, 0);
    end
    check("rm_ready_after", cmd_ready, 1);
    run("rm_next", 2, 0, 3, 1, 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
